// File: rtl/fft_bfly_tw_unit_if.sv
// Butterfly operand/result bundle: sum and difference paths,
// each with its own valid strobe.
interface fft_bfly_tw_unit_if #(
    parameter int DATA_W = 16,
    parameter int IDX_W  = 8
);
    logic [2*DATA_W-1:0] add_a;
    logic [2*DATA_W-1:0] add_b;
    logic                add_vld;
    logic [2*DATA_W-1:0] sub_a;
    logic [2*DATA_W-1:0] sub_b;
    logic                sub_vld;
    logic [IDX_W-1:0]    tw_idx;
    logic [2*DATA_W-1:0] add_out;
    logic                add_out_vld;
    logic [2*DATA_W-1:0] mult_out;
    logic                mult_out_vld;

    modport master (
        output add_a, add_b, add_vld,
        output sub_a, sub_b, sub_vld, tw_idx,
        input  add_out, add_out_vld,
        input  mult_out, mult_out_vld
    );

    modport slave (
        input  add_a, add_b, add_vld,
        input  sub_a, sub_b, sub_vld, tw_idx,
        output add_out, add_out_vld,
        output mult_out, mult_out_vld
    );
endinterface

// File: rtl/fft_bfly_tw_unit.sv
// Radix-2 DIF butterfly: saturated sum (1 cycle) and
// (a-b)*W^k with built-in twiddle ROM (3 cycles).
module fft_bfly_tw_unit #(
    parameter int DATA_W  = 16,
    parameter int TW_W    = 16,
    parameter int TW_FRAC = 14,
    parameter int N_FFT   = 512,
    parameter int IDX_W   = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    fft_bfly_tw_unit_if.slave  bus
);
    localparam int  DEPTH = N_FFT / 2;
    localparam int  DW1   = DATA_W + 1;
    localparam int  PW    = DATA_W + TW_W + 1;
    localparam int  RW    = PW + 2;
    localparam int  SW    = RW + 1;
    localparam real PI    = 3.14159265358979323846;
    localparam real SCALE = 1.0 * (1 << TW_FRAC);
    localparam int  TW_MAX = (1 << (TW_W - 1)) - 1;
    localparam int  TW_MIN = -(1 << (TW_W - 1));

    localparam logic signed [SW-1:0] SMAX = SW'((1 << (DATA_W - 1)) - 1);
    localparam logic signed [SW-1:0] SMIN = SW'(-(1 << (DATA_W - 1)));
    localparam logic signed [RW-1:0] RND  = RW'(1 << (TW_FRAC - 1));

    // Quantise a unit-circle component to TW_FRAC fraction bits.
    function automatic int q_tw(input real x);
        real y;
        int  r;
        y = x * SCALE;
        r = (y >= 0.0) ? $rtoi(y + 0.5) : -$rtoi(0.5 - y);
        if (r > TW_MAX) r = TW_MAX;
        if (r < TW_MIN) r = TW_MIN;
        return r;
    endfunction

    function automatic logic [DATA_W-1:0] sat(input logic signed [SW-1:0] x);
        if (x > SMAX) return SMAX[DATA_W-1:0];
        if (x < SMIN) return SMIN[DATA_W-1:0];
        return x[DATA_W-1:0];
    endfunction

    // Twiddle table W^k = exp(-j*2*pi*k/N), fixed at elaboration.
    logic signed [TW_W-1:0] rom_wr [DEPTH];
    logic signed [TW_W-1:0] rom_wi [DEPTH];

    for (genvar k = 0; k < DEPTH; k++) begin : g_rom
        localparam int WR = q_tw($cos(2.0 * PI * k / N_FFT));
        localparam int WI = q_tw(-$sin(2.0 * PI * k / N_FFT));
        assign rom_wr[k] = WR[TW_W-1:0];
        assign rom_wi[k] = WI[TW_W-1:0];
    end

    // ---------------- sum path ----------------
    logic signed [DATA_W-1:0] aa_r, aa_i, ab_r, ab_i;
    logic signed [DW1-1:0]    sum_r, sum_i;
    logic [2*DATA_W-1:0]      add_out_d, add_out_q;
    logic                     add_vld_q;

    assign aa_r  = bus.add_a[2*DATA_W-1:DATA_W];
    assign aa_i  = bus.add_a[DATA_W-1:0];
    assign ab_r  = bus.add_b[2*DATA_W-1:DATA_W];
    assign ab_i  = bus.add_b[DATA_W-1:0];
    assign sum_r = DW1'(aa_r) + DW1'(ab_r);
    assign sum_i = DW1'(aa_i) + DW1'(ab_i);
    assign add_out_d = {sat(SW'(sum_r)), sat(SW'(sum_i))};

    // Sum register; idle cycles present zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            add_vld_q <= 1'b0;
            add_out_q <= '0;
        end else begin
            add_vld_q <= bus.add_vld;
            add_out_q <= bus.add_vld ? add_out_d : '0;
        end
    end

    // ---------------- difference path ----------------
    logic signed [DATA_W-1:0] sa_r, sa_i, sb_r, sb_i;
    logic signed [DW1-1:0]    d_r_d, d_i_d;
    logic signed [DW1-1:0]    d_r_q, d_i_q;
    logic signed [TW_W-1:0]   wr_q, wi_q;
    logic                     v1_q;

    assign sa_r  = bus.sub_a[2*DATA_W-1:DATA_W];
    assign sa_i  = bus.sub_a[DATA_W-1:0];
    assign sb_r  = bus.sub_b[2*DATA_W-1:DATA_W];
    assign sb_i  = bus.sub_b[DATA_W-1:0];
    assign d_r_d = DW1'(sa_r) - DW1'(sb_r);
    assign d_i_d = DW1'(sa_i) - DW1'(sb_i);

    // Stage 1: difference and twiddle lookup.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q  <= 1'b0;
            d_r_q <= '0;
            d_i_q <= '0;
            wr_q  <= '0;
            wi_q  <= '0;
        end else begin
            v1_q <= bus.sub_vld;
            if (bus.sub_vld) begin
                d_r_q <= d_r_d;
                d_i_q <= d_i_d;
                wr_q  <= rom_wr[bus.tw_idx];
                wi_q  <= rom_wi[bus.tw_idx];
            end
        end
    end

    logic signed [PW-1:0] p_rr_q, p_ii_q, p_ri_q, p_ir_q;
    logic                 v2_q;

    // Stage 2: the four partial products.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2_q   <= 1'b0;
            p_rr_q <= '0;
            p_ii_q <= '0;
            p_ri_q <= '0;
            p_ir_q <= '0;
        end else begin
            v2_q <= v1_q;
            if (v1_q) begin
                p_rr_q <= PW'(d_r_q) * PW'(wr_q);
                p_ii_q <= PW'(d_i_q) * PW'(wi_q);
                p_ri_q <= PW'(d_r_q) * PW'(wi_q);
                p_ir_q <= PW'(d_i_q) * PW'(wr_q);
            end
        end
    end

    logic signed [RW-1:0] re_w, im_w, re_s, im_s;
    logic [2*DATA_W-1:0]  mult_out_d, mult_out_q;
    logic                 v3_q;

    assign re_w = RW'(p_rr_q) - RW'(p_ii_q);
    assign im_w = RW'(p_ri_q) + RW'(p_ir_q);
    assign re_s = (re_w + RND) >>> TW_FRAC;
    assign im_s = (im_w + RND) >>> TW_FRAC;
    assign mult_out_d = {sat(SW'(re_s)), sat(SW'(im_s))};

    // Stage 3: round, saturate, register; idle cycles present zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v3_q       <= 1'b0;
            mult_out_q <= '0;
        end else begin
            v3_q       <= v2_q;
            mult_out_q <= v2_q ? mult_out_d : '0;
        end
    end

    assign bus.add_out      = add_out_q;
    assign bus.add_out_vld  = add_vld_q;
    assign bus.mult_out     = mult_out_q;
    assign bus.mult_out_vld = v3_q;
endmodule

// File: tb/tb_fft_bfly_tw_unit.sv
// Bench for fft_bfly_tw_unit: directed cases plus random
// traffic against an integer/real reference model.
module tb_fft_bfly_tw_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fft_bfly_tw_unit_if bus ();

    fft_bfly_tw_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int tw_r [256];
    int tw_i [256];

    logic [32:0] mq [$];
    logic [31:0] a_exp;
    logic        a_vexp;
    logic [32:0] m_exp;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int sat16(input longint x);
        if (x > 32767) return 32767;
        if (x < -32768) return -32768;
        return int'(x);
    endfunction

    function automatic logic [31:0] pack(input longint r, input longint i);
        int sr, si;
        sr = sat16(r);
        si = sat16(i);
        return {sr[15:0], si[15:0]};
    endfunction

    function automatic logic [31:0] add_model(input logic [31:0] a,
                                              input logic [31:0] b);
        int ar, ai, br, bi;
        ar = $signed(a[31:16]);
        ai = $signed(a[15:0]);
        br = $signed(b[31:16]);
        bi = $signed(b[15:0]);
        return pack(ar + br, ai + bi);
    endfunction

    // Complex multiply by the rounded twiddle, round-half-up to integer.
    function automatic logic [31:0] mult_model(input logic [31:0] a,
                                               input logic [31:0] b,
                                               input int k);
        longint dr, di, re, im;
        dr = longint'($signed(a[31:16])) - longint'($signed(b[31:16]));
        di = longint'($signed(a[15:0])) - longint'($signed(b[15:0]));
        re = dr * tw_r[k] - di * tw_i[k];
        im = dr * tw_i[k] + di * tw_r[k];
        return pack((re + 8192) >>> 14, (im + 8192) >>> 14);
    endfunction

    // Advance one clock; model the edge, then compare all outputs.
    task automatic tick();
        @(posedge clk);
        if (rst_n) begin
            a_vexp = bus.add_vld;
            a_exp  = bus.add_vld ? add_model(bus.add_a, bus.add_b) : 32'h0;
            mq.push_back({bus.sub_vld, bus.sub_vld ?
                mult_model(bus.sub_a, bus.sub_b, int'(bus.tw_idx)) : 32'h0});
        end else begin
            a_vexp = 1'b0;
            a_exp  = 32'h0;
            mq.push_back(33'h0);
        end
        m_exp = mq.pop_front();
        #1;
        chk("add_out_vld", {31'h0, bus.add_out_vld}, {31'h0, a_vexp});
        chk("add_out", bus.add_out, a_exp);
        chk("mult_out_vld", {31'h0, bus.mult_out_vld}, {31'h0, m_exp[32]});
        chk("mult_out", bus.mult_out, m_exp[31:0]);
    endtask

    task automatic flush_model();
        mq.delete();
        mq.push_back(33'h0);
        mq.push_back(33'h0);
    endtask

    task automatic idle();
        bus.add_vld = 1'b0;
        bus.sub_vld = 1'b0;
        bus.add_a   = '0;
        bus.add_b   = '0;
        bus.sub_a   = '0;
        bus.sub_b   = '0;
        bus.tw_idx  = '0;
    endtask

    task automatic put_sub(input logic [31:0] a, input logic [31:0] b,
                           input int k);
        bus.sub_vld = 1'b1;
        bus.sub_a   = a;
        bus.sub_b   = b;
        bus.tw_idx  = 8'(k);
    endtask

    function automatic logic [15:0] rnd_val();
        case ($urandom_range(0, 5))
            0:       return 16'h7FFF;
            1:       return 16'h8000;
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        idle();
        flush_model();
        for (int k = 0; k < 256; k++) begin
            tw_r[k] = $rtoi($floor(16384.0 * $cos(2.0 * 3.14159265358979323846 * k / 512.0) + 0.5));
            tw_i[k] = $rtoi($floor(-16384.0 * $sin(2.0 * 3.14159265358979323846 * k / 512.0) + 0.5));
        end

        // Hand-computed anchors for the model itself.
        chk("tw0_r", tw_r[0], 32'd16384);
        chk("tw0_i", tw_i[0], 32'd0);
        chk("tw64_r", tw_r[64], 32'd11585);
        chk("tw64_i", tw_i[64], -32'sd11585);
        chk("tw128_r", tw_r[128], 32'd0);
        chk("tw128_i", tw_i[128], -32'sd16384);
        chk("model_add", add_model({16'd100, 16'hFFCE}, {16'd20, 16'd30}),
            {16'h0078, 16'hFFEC});
        chk("model_mul", mult_model({16'd1000, 16'd500}, {16'd200, 16'd100}, 128),
            {16'h0190, 16'hFCE0});

        // Reset state.
        tick();
        tick();
        #2 rst_n = 1'b1;
        tick();

        // Sum basic, then idle.
        bus.add_vld = 1'b1;
        bus.add_a   = {16'd100, 16'hFFCE};
        bus.add_b   = {16'd20, 16'd30};
        tick();
        chk("sum_lit", bus.add_out, {16'h0078, 16'hFFEC});
        chk("sum_lit_vld", {31'h0, bus.add_out_vld}, 32'd1);
        idle();
        tick();
        chk("sum_idle_vld", {31'h0, bus.add_out_vld}, 32'd0);

        // Sum saturation.
        bus.add_vld = 1'b1;
        bus.add_a   = {16'h7FFF, 16'h8000};
        bus.add_b   = {16'h0001, 16'hFFFF};
        tick();
        chk("sum_sat", bus.add_out, {16'h7FFF, 16'h8000});
        idle();

        // Diff k=0, single sample.
        put_sub({16'd1000, 16'd500}, {16'd200, 16'd100}, 0);
        tick();
        idle();
        tick();
        chk("diff_early_vld", {31'h0, bus.mult_out_vld}, 32'd0);
        tick();
        chk("diff_k0", bus.mult_out, {16'h0320, 16'h0190});
        chk("diff_k0_vld", {31'h0, bus.mult_out_vld}, 32'd1);

        // Stream k = 0, 64, 128 back to back.
        put_sub({16'd1000, 16'd500}, {16'd200, 16'd100}, 0);
        tick();
        put_sub({16'd16384, 16'd0}, 32'h0, 64);
        tick();
        put_sub({16'd1000, 16'd500}, {16'd200, 16'd100}, 128);
        tick();
        idle();
        chk("stream0", bus.mult_out, {16'h0320, 16'h0190});
        tick();
        chk("stream64", bus.mult_out, {16'h2D41, 16'hD2BF});
        tick();
        chk("stream128", bus.mult_out, {16'h0190, 16'hFCE0});
        chk("stream128_vld", {31'h0, bus.mult_out_vld}, 32'd1);
        tick();
        chk("stream_end_vld", {31'h0, bus.mult_out_vld}, 32'd0);

        // Both paths in the same cycle.
        bus.add_vld = 1'b1;
        bus.add_a   = {16'd100, 16'hFFCE};
        bus.add_b   = {16'd20, 16'd30};
        put_sub({16'd1000, 16'd500}, {16'd200, 16'd100}, 128);
        tick();
        idle();
        chk("conc_sum", bus.add_out, {16'h0078, 16'hFFEC});
        tick();
        tick();
        chk("conc_mul", bus.mult_out, {16'h0190, 16'hFCE0});

        // Random traffic with a mid-stream asynchronous reset.
        for (int c = 0; c < 400; c++) begin
            bus.add_vld = 1'($urandom_range(0, 1));
            bus.add_a   = {rnd_val(), rnd_val()};
            bus.add_b   = {rnd_val(), rnd_val()};
            bus.sub_vld = ($urandom_range(0, 3) != 0);
            bus.sub_a   = {rnd_val(), rnd_val()};
            bus.sub_b   = {rnd_val(), rnd_val()};
            bus.tw_idx  = 8'($urandom);
            if (c == 200) begin
                #2 rst_n = 1'b0;
                #1;
                chk("rst_add_vld", {31'h0, bus.add_out_vld}, 32'd0);
                chk("rst_add", bus.add_out, 32'h0);
                chk("rst_mul_vld", {31'h0, bus.mult_out_vld}, 32'd0);
                chk("rst_mul", bus.mult_out, 32'h0);
                flush_model();
                tick();
                tick();
                rst_n = 1'b1;
            end
            tick();
        end
        idle();
        repeat (4) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/fft_bfly_tw_unit.md
Name: fft_bfly_tw_unit

Overview:
Radix-2 decimation-in-frequency butterfly datapath with an integrated twiddle ROM, used inside each FFT pipeline stage.
- Sum path: a + b.
- Difference path: (a − b) · W^k, where W = exp(−j2π/512).
- The stage controller drives both paths with independent valid strobes and routes the results to the stage output mux and the delay buffer.

Parameters:
DATA_W, 16, bit width of each signed real/imag component.
TW_W, 16, bit width of each signed twiddle component.
TW_FRAC, 14, fractional bits of twiddle (1.0 = 16384).
N_FFT, 512, FFT size the ROM is built for; ROM depth = N_FFT/2.
IDX_W, 8, twiddle index width = log2(N_FFT/2).

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
add_a  in  2*DATA_W  sum operand A, {real[31:16], imag[15:0]}, two's complement
add_b  in  2*DATA_W  sum operand B, same packing
add_vld  in  1  add_a/add_b valid
sub_a  in  2*DATA_W  difference minuend
sub_b  in  2*DATA_W  difference subtrahend
sub_vld  in  1  sub_a/sub_b/tw_idx valid
tw_idx  in  IDX_W  twiddle index k, 0..N_FFT/2−1
add_out  out  2*DATA_W  saturated A+B
add_out_vld  out  1  add_out valid
mult_out  out  2*DATA_W  (sub_a−sub_b)·W^k, rounded, saturated
mult_out_vld  out  1  mult_out valid

Behaviour:
- Interface (already decided): one clock; reset is asynchronous and active-low; the clock port is named clk and the reset port rst_n.
- Reset: all pipeline registers, add_out, mult_out and both valid outputs clear to 0 immediately on rst_n low, independent of clk.
- The two paths are fully independent: no stalls or backpressure, and both may be valid in the same cycle.

Sum path (1-cycle latency):
- On a clk edge with add_vld=1, the next cycle presents add_out = sat16(a_r+b_r), sat16(a_i+b_i), with add_out_vld=1.
- When add_vld=0, add_out_vld=0 next cycle and add_out holds 0.
- Sums are computed at 17 bits, then saturated to [−32768, 32767].

Difference path (3-cycle latency, fully pipelined, one new input accepted per cycle):
- Stage 1: register d = a − b at 17 bits per component; register ROM[tw_idx] = (wr, wi).
- Stage 2: register the four products dr·wr, di·wi, dr·wi, di·wr (33-bit signed).
- Stage 3: compute re = dr·wr − di·wi and im = dr·wi + di·wr. Add rounding constant 2^(TW_FRAC−1), arithmetic-shift right by TW_FRAC, saturate to 16 bits, register.
- The valid bit travels with the data through 3 flops. Data registers load only when the valid is set; otherwise mult_out is forced to 0 when mult_out_vld=0.

Twiddle ROM:
- ROM[k] = (round(16384·cos(2πk/512)), round(−16384·sin(2πk/512))), clamped to [−32768, 32767]. ROM[0] = (16384, 0).
- Contents are built at elaboration time with no runtime writes.

Boundary conditions:
- Back-to-back sub_vld pulses yield back-to-back mult_out_vld.
- A reset during operation flushes all in-flight samples.
- tw_idx is a don't-care when sub_vld=0.

Test Plan:
- Reset: assert rst_n=0 mid-stream, between clock edges -> all outputs 0 and valids 0 at once; the first valid output appears only 1 (sum) / 3 (diff) cycles after new inputs.
- Sum: add_a=(100,−50), add_b=(20,30), add_vld=1 -> one cycle later add_out=(120,−20), add_out_vld=1; next cycle with add_vld=0 gives add_out_vld=0.
- Sum saturation: add_a=(32767,−32768), add_b=(1,−1) -> add_out=(32767,−32768).
- Diff with k=0: sub_a=(1000,500), sub_b=(200,100), tw_idx=0 -> 3 cycles later mult_out=(800,400). With k=128 (W=−j) -> (400,−800).
- Diff with k=64: sub_a=(16384,0), sub_b=0, tw_idx=64 -> W=(11585,−11585), mult_out=(11585,−11585). Streaming indices 0,64,128 on consecutive cycles gives three consecutive valid results in order.
- Concurrency: add_vld and sub_vld pulsed in the same cycle -> add_out valid at +1 and mult_out valid at +3, each with correct values and no interference.
